// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ready bus between the fetch sequencer and the memory.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues fetches, drives IF freeze/flush.
// Optional FETCH_STALL_CNT_EN adds saturating stall_cycles/discard_count counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  fetch_ctrl_if.master        imem,
  input  logic                hazard,
  input  logic                branch_taken,
  input  logic [31:0]         branch_addr,
  output logic [31:0]         pc_out,
  output logic [31:0]         inst_out,
  output logic                if_freeze,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]         stall_cycles,
  output logic [15:0]         discard_count,
`endif
  output logic                if_flush
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] stale_q, stale_d;
  logic [31:0] pc_next;
  logic        drop;

  assign pc_next = pc_q + PC_STEP;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_d          = buf_q;
    stale_d        = stale_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    pc_out         = 32'd0;
    inst_out       = 32'd0;
    if_freeze      = 1'b1;
    if_flush       = 1'b0;
    drop           = 1'b0;

    case (state_q)
      FETCH: begin
        imem.imem_req = 1'b1;
        if (branch_taken) begin
          if_flush  = 1'b1;
          if_freeze = 1'b0;
          pc_d      = branch_addr;
          if (imem.imem_ready) begin
            drop = 1'b1;
          end else begin
            // Request can't be aborted; remember its address for the drain.
            stale_d = pc_q;
            state_d = DISCARD;
          end
        end else if (imem.imem_ready) begin
          if (hazard) begin
            buf_d   = imem.imem_rdata;
            state_d = HOLD;
          end else begin
            if_freeze = 1'b0;
            inst_out  = imem.imem_rdata;
            pc_out    = pc_next;
            pc_d      = pc_next;
          end
        end
      end

      HOLD: begin
        if (branch_taken) begin
          if_flush  = 1'b1;
          if_freeze = 1'b0;
          pc_d      = branch_addr;
          state_d   = FETCH;
        end else if (!hazard) begin
          if_freeze = 1'b0;
          inst_out  = buf_q;
          pc_out    = pc_next;
          pc_d      = pc_next;
          state_d   = FETCH;
        end
      end

      DISCARD: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = stale_q;
        if (branch_taken) begin
          if_flush  = 1'b1;
          if_freeze = 1'b0;
          pc_d      = branch_addr;
        end
        if (imem.imem_ready) begin
          drop    = 1'b1;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
      stale_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      stale_q <= stale_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= 32'd0;
      discard_count <= 16'd0;
    end else begin
      if (if_freeze && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (drop && (discard_count != '1))     discard_count <= discard_count + 16'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl; the bench itself plays the memory.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        if_freeze;
  logic        if_flush;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] discard_count;
`endif

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .branch_addr   (branch_addr),
    .pc_out        (pc_out),
    .inst_out      (inst_out),
    .if_freeze     (if_freeze),
`ifdef FETCH_STALL_CNT_EN
    .stall_cycles  (stall_cycles),
    .discard_count (discard_count),
`endif
    .if_flush      (if_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hz;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_frz;
    logic        e_fl;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic hz, logic br, logic [31:0] baddr, logic rdy,
                              logic [31:0] rdata, logic e_req, logic [31:0] e_addr,
                              logic e_frz, logic e_fl, logic [31:0] e_inst,
                              logic [31:0] e_pc);
    vec_t v;
    v.hz = hz; v.br = br; v.baddr = baddr; v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_frz = e_frz; v.e_fl = e_fl;
    v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    hazard                = v.hz;
    branch_taken          = v.br;
    branch_addr           = v.baddr;
    imem_bus.imem_ready   = v.rdy;
    imem_bus.imem_rdata   = v.rdata;
  endtask

  initial begin
    int   exp_stall;
    logic ok;

    rst = 1'b0;
    hazard = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'd0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'd0;

    //        hz br baddr          rdy rdata          req addr           frz fl inst          pc
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hA000_0000, 1, 32'h0,         0, 0, 32'hA000_0000, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hA000_0001, 1, 32'h4,         0, 0, 32'hA000_0001, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'hE3A0_1005, 1, 32'h8,         1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 32'hE3A0_1005, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'hC,         1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hA000_0003, 1, 32'hC,         0, 0, 32'hA000_0003, 32'h10));
    // Branch while fetch of 0x10 is still waiting: drain it in DISCARD.
    vecs.push_back(mk(0, 1, 32'h100,       0, 32'h0,         1, 32'h10,        0, 1, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h10,        1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hDEAD_DEAD, 1, 32'h10,        1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h100,       1, 0, 32'h0,         32'h0));
    // Branch in the same cycle as ready: no DISCARD cycle.
    vecs.push_back(mk(0, 1, 32'h200,       1, 32'hA000_0005, 1, 32'h100,       0, 1, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h200,       1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'hBEEF_BEEF, 1, 32'h200,       1, 0, 32'h0,         32'h0));
    // Branch during HOLD: buffered word never delivered.
    vecs.push_back(mk(1, 1, 32'h300,       0, 32'h0,         0, 32'h0,         0, 1, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h300,       1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hA000_0007, 1, 32'h300,       0, 0, 32'hA000_0007, 32'h304));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hA000_0008, 1, 32'h304,       0, 0, 32'hA000_0008, 32'h308));
    // Branch into DISCARD, re-branch inside DISCARD, then branch with ready.
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,         1, 32'h308,       0, 1, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, 32'h400,       0, 32'h0,         1, 32'h308,       0, 1, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 32'h1111_1111, 1, 32'h308,       0, 1, 32'h0,         32'h0));
    // Fetch at the top of the address space wraps to 0.
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hA000_0009, 1, 32'hFFFF_FFFC, 0, 0, 32'hA000_0009, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         1, 0, 32'h0,         32'h0));

    #3;
    chk("reset imem_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("reset imem_addr", imem_bus.imem_addr, 32'h0);
    chk("reset if_freeze", {31'd0, if_freeze}, 32'd1);
    chk("reset if_flush", {31'd0, if_flush}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    chk("reset stall_cycles", stall_cycles, 32'd0);
    chk("reset discard_count", {16'd0, discard_count}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    exp_stall = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      apply(vecs[i]);
      #1;
      ok = (imem_bus.imem_req === vecs[i].e_req) &&
           (!vecs[i].e_req || (imem_bus.imem_addr === vecs[i].e_addr)) &&
           (if_freeze === vecs[i].e_frz) && (if_flush === vecs[i].e_fl) &&
           (vecs[i].e_frz || vecs[i].e_fl ||
            ((inst_out === vecs[i].e_inst) && (pc_out === vecs[i].e_pc)));
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL vec%0d: got req=%b addr=%h frz=%b fl=%b inst=%h pc=%h, expected req=%b addr=%h frz=%b fl=%b inst=%h pc=%h",
                 i, imem_bus.imem_req, imem_bus.imem_addr, if_freeze, if_flush, inst_out,
                 pc_out, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_frz, vecs[i].e_fl,
                 vecs[i].e_inst, vecs[i].e_pc);
      end
      if (vecs[i].e_frz) exp_stall++;
    end
    @(posedge clk);
    #1;
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, exp_stall);
    chk("discard_count", {16'd0, discard_count}, 32'd3);
`endif

    // Redirect to 0x500, then pull reset in the middle of the request.
    @(negedge clk);
    hazard = 1'b0;
    branch_taken = 1'b1;
    branch_addr = 32'h500;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'h2222_2222;
    #1;
    chk("redirect flush", {31'd0, if_flush}, 32'd1);
    @(negedge clk);
    branch_taken = 1'b0;
    imem_bus.imem_ready = 1'b0;
    #1;
    chk("pre-reset imem_addr", imem_bus.imem_addr, 32'h500);
    chk("pre-reset if_freeze", {31'd0, if_freeze}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async reset imem_addr", imem_bus.imem_addr, 32'h0);
    chk("async reset imem_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("async reset if_freeze", {31'd0, if_freeze}, 32'd1);
    chk("async reset if_flush", {31'd0, if_flush}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    chk("async reset stall_cycles", stall_cycles, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'h3333_3333;
    #1;
    chk("post-reset inst_out", inst_out, 32'h3333_3333);
    chk("post-reset pc_out", pc_out, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
